// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: turns START/STOP/WRITE/READ commands into open-drain
// SCL/SDA waveforms built from four DIV-clock quarters per bit cell.
module i2c_byte_master #(
    parameter int unsigned DIV            = 25,
    parameter int unsigned I2C_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd,
    input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_ack,
    output logic                      rsp_err,
    output logic                      busy,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_oe,
    output logic                      sda_oe
);

    localparam int unsigned W        = I2C_DATA_WIDTH;
    localparam logic [15:0] QLAST    = 16'(DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'(W);

    localparam logic [2:0] C_START    = 3'd0;
    localparam logic [2:0] C_STOP     = 3'd1;
    localparam logic [2:0] C_WRITE    = 3'd2;
    localparam logic [2:0] C_READ_ACK = 3'd3;
    localparam logic [2:0] C_READ_NAK = 3'd4;

    typedef enum logic [2:0] {IDLE, START_SEQ, STOP_SEQ, BIT, RESP} state_t;

    state_t         state, state_n;
    logic [15:0]    qcnt, qcnt_n;
    logic [1:0]     quarter, quarter_n;
    logic [3:0]     bit_idx, bit_idx_n;
    logic [W-1:0]   shreg, shreg_n;
    logic           is_read, is_read_n;
    logic           read_nak, read_nak_n;
    logic           ack_q, ack_q_n;
    logic           scl_oe_n, sda_oe_n, busy_n, cmd_ready_n;
    logic           rsp_valid_n, rsp_ack_n, rsp_err_n;
    logic [W-1:0]   rsp_rdata_n;
    logic           freeze, q_end, sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            quarter   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            is_read   <= 1'b0;
            read_nak  <= 1'b0;
            ack_q     <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_ack   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            quarter   <= quarter_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            is_read   <= is_read_n;
            read_nak  <= read_nak_n;
            ack_q     <= ack_q_n;
            scl_oe    <= scl_oe_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_ack   <= rsp_ack_n;
            rsp_err   <= rsp_err_n;
        end
    end

    // Line levels are registered one edge ahead: the values for a quarter are
    // loaded on the edge that ends the previous quarter (or accepts the command).
    always_comb begin
        state_n     = state;
        qcnt_n      = qcnt;
        quarter_n   = quarter;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        is_read_n   = is_read;
        read_nak_n  = read_nak;
        ack_q_n     = ack_q;
        scl_oe_n    = scl_oe;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        cmd_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_ack_n   = rsp_ack;
        rsp_err_n   = rsp_err;

        freeze = !scl_oe && !scl_i;
        q_end  = (qcnt == QLAST) && !freeze;
        sample = (state == BIT) && (quarter == 2'd3) && (qcnt == '0) && !freeze;

        case (state)
            IDLE, RESP: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    qcnt_n    = '0;
                    quarter_n = '0;
                    bit_idx_n = '0;
                    case (cmd)
                        C_START: begin
                            state_n     = START_SEQ;
                            cmd_ready_n = 1'b0;
                            sda_oe_n    = 1'b0;
                        end
                        C_STOP: begin
                            if (busy) begin
                                state_n     = STOP_SEQ;
                                cmd_ready_n = 1'b0;
                                sda_oe_n    = 1'b1;
                            end else begin
                                state_n     = RESP;
                                rsp_valid_n = 1'b1;
                                rsp_err_n   = 1'b0;
                            end
                        end
                        C_WRITE, C_READ_ACK, C_READ_NAK: begin
                            if (busy) begin
                                state_n     = BIT;
                                cmd_ready_n = 1'b0;
                                is_read_n   = (cmd != C_WRITE);
                                read_nak_n  = (cmd == C_READ_NAK);
                                shreg_n     = cmd_wdata;
                                scl_oe_n    = 1'b1;
                                sda_oe_n    = (cmd == C_WRITE) ? ~cmd_wdata[W-1] : 1'b0;
                            end else begin
                                state_n     = RESP;
                                rsp_valid_n = 1'b1;
                                rsp_err_n   = 1'b1;
                            end
                        end
                        default: begin
                            state_n     = RESP;
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = 1'b1;
                        end
                    endcase
                end
            end

            START_SEQ, STOP_SEQ, BIT: begin
                if (!freeze)
                    qcnt_n = qcnt + 16'd1;
                if (sample) begin
                    if (bit_idx == LAST_BIT)
                        ack_q_n = !sda_i;
                    else
                        shreg_n = {shreg[W-2:0], sda_i};
                end
                if (q_end) begin
                    qcnt_n    = '0;
                    quarter_n = quarter + 2'd1;
                    if (state == START_SEQ) begin
                        case (quarter)
                            2'd0:    scl_oe_n = 1'b0;
                            2'd1:    sda_oe_n = 1'b1;
                            2'd2:    scl_oe_n = 1'b1;
                            default: busy_n   = 1'b1;
                        endcase
                    end else if (state == STOP_SEQ) begin
                        case (quarter)
                            2'd0:    scl_oe_n = 1'b0;
                            2'd1:    sda_oe_n = 1'b0;
                            2'd2:    ;
                            default: busy_n   = 1'b0;
                        endcase
                    end else begin
                        if (quarter == 2'd1)
                            scl_oe_n = 1'b0;
                        if (quarter == 2'd3) begin
                            scl_oe_n = 1'b1;
                            if (bit_idx != LAST_BIT) begin
                                bit_idx_n = bit_idx + 4'd1;
                                if (bit_idx_n == LAST_BIT)
                                    sda_oe_n = is_read && !read_nak;
                                else
                                    sda_oe_n = is_read ? 1'b0 : ~shreg[W-1];
                            end else if (is_read) begin
                                rsp_rdata_n = shreg;
                            end else begin
                                rsp_ack_n = ack_q;
                            end
                        end
                    end
                    if (quarter == 2'd3 && (state != BIT || bit_idx == LAST_BIT)) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b0;
                        cmd_ready_n = 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master (DIV=4) with a small behavioural I2C
// slave at address 0x22 sharing the pulled-up scl/sda lines.
module tb_i2c_byte_master;

    localparam logic [2:0] C_START    = 3'd0;
    localparam logic [2:0] C_STOP     = 3'd1;
    localparam logic [2:0] C_WRITE    = 3'd2;
    localparam logic [2:0] C_READ_ACK = 3'd3;
    localparam logic [2:0] C_READ_NAK = 3'd4;
    localparam logic [6:0] SLV_ADDR   = 7'h22;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack, rsp_err, busy;
    logic       scl_oe, sda_oe;
    logic       scl, sda;
    logic       ext_scl = 1'b0;
    logic       slv_drv = 1'b0;

    assign scl = ~(scl_oe | ext_scl);
    assign sda = ~(sda_oe | slv_drv);

    i2c_byte_master #(.DIV(4), .I2C_DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
        .busy(busy), .scl_i(scl), .sda_i(sda), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int r_lat;
    logic [7:0] r_rd;
    logic r_ack, r_err;
    int ev0;

    // Line activity counter: any change of the master's drive counts.
    logic [1:0] last_oe = 2'b00;
    int line_ev = 0;
    always @(negedge clk) begin
        if ({scl_oe, sda_oe} !== last_oe) line_ev++;
        last_oe = {scl_oe, sda_oe};
    end

    // Behavioural slave: samples the lines mid-cycle, acks its address and
    // written bytes, and returns s_tx_bytes on reads.
    logic p_scl = 1'b1, p_sda = 1'b1;
    logic s_act = 1'b0, s_tx = 1'b0, s_addr_ph = 1'b0, s_op = 1'b0, s_mnak = 1'b0;
    logic s_tx_i = 1'b0;
    logic [7:0] s_sh = '0, s_txsh = '0, s_wr_byte = '0;
    logic [1:0] s_mack = 2'b11;
    int s_bit = 0, s_wr_cnt = 0;
    logic [7:0] s_tx_bytes [0:1];

    always @(negedge clk) begin
        if (p_scl && scl && p_sda && !sda) begin
            s_act = 1'b1; s_tx = 1'b0; s_addr_ph = 1'b1; s_bit = 0; slv_drv = 1'b0;
            s_wr_cnt = 0; s_mack = 2'b11; s_tx_i = 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
            s_act = 1'b0; slv_drv = 1'b0;
        end else if (s_act) begin
            if (!p_scl && scl) begin
                if (s_bit < 8 && !s_tx) s_sh = {s_sh[6:0], sda};
                if (s_bit == 8 && s_tx) begin s_mnak = sda; s_mack = {s_mack[0], sda}; end
                s_bit++;
            end else if (p_scl && !scl) begin
                if (s_bit == 8) begin
                    slv_drv = 1'b0;
                    if (!s_tx) begin
                        if (!s_addr_ph) begin
                            slv_drv = 1'b1; s_wr_byte = s_sh; s_wr_cnt++;
                        end else if (s_sh[7:1] == SLV_ADDR) begin
                            slv_drv = 1'b1; s_op = s_sh[0];
                        end else begin
                            s_act = 1'b0;
                        end
                    end
                end else if (s_bit == 9) begin
                    s_bit = 0; slv_drv = 1'b0;
                    if (s_addr_ph) begin
                        s_addr_ph = 1'b0;
                        if (s_op) begin
                            s_tx = 1'b1; s_txsh = s_tx_bytes[s_tx_i]; s_tx_i = ~s_tx_i;
                            slv_drv = ~s_txsh[7];
                        end
                    end else if (s_tx) begin
                        if (s_mnak) s_act = 1'b0;
                        else begin
                            s_txsh = s_tx_bytes[s_tx_i]; s_tx_i = ~s_tx_i;
                            slv_drv = ~s_txsh[7];
                        end
                    end
                end else if (s_bit >= 1 && s_tx) begin
                    s_txsh = s_txsh << 1; slv_drv = ~s_txsh[7];
                end
            end
        end
        p_scl = scl; p_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        int n;
        @(negedge clk);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd = c; cmd_wdata = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd = 3'd7; cmd_wdata = ~d;
    endtask

    task automatic wait_rsp();
        r_lat = 1;
        while (rsp_valid !== 1'b1 && r_lat < 3000) begin @(posedge clk); #1; r_lat++; end
        r_rd = rsp_rdata; r_ack = rsp_ack; r_err = rsp_err;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [7:0] d);
        issue(c, d);
        wait_rsp();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd = '0; cmd_wdata = '0;
        s_tx_bytes[0] = 8'h3C; s_tx_bytes[1] = 8'hC3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_ack",   32'(rsp_ack),   32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_scl_oe",    32'(scl_oe),    32'd0);
        chk("rst_sda_oe",    32'(sda_oe),    32'd0);

        // idle STOP and illegal WRITE: one-cycle responses, no line activity
        #1 ev0 = line_ev;
        do_cmd(C_STOP, 8'h00);
        chk("idle_stop_lat", r_lat, 32'd1);
        chk("idle_stop_err", 32'(r_err), 32'd0);
        do_cmd(C_WRITE, 8'h55);
        chk("illegal_wr_lat",   r_lat, 32'd1);
        chk("illegal_wr_err",   32'(r_err), 32'd1);
        chk("illegal_wr_ack",   32'(r_ack), 32'd0);
        chk("illegal_wr_rdata", 32'(r_rd),  32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("illegal_wr_lines", line_ev, ev0);
        chk("illegal_wr_busy",  32'(busy), 32'd0);

        // two-byte write to slave 0x22
        do_cmd(C_START, 8'h00);
        chk("wr_start_lat",  r_lat, 32'd17);
        chk("wr_start_err",  32'(r_err), 32'd0);
        chk("wr_start_busy", 32'(busy), 32'd1);
        do_cmd(C_WRITE, 8'h44);
        chk("wr_addr_lat", r_lat, 32'd145);
        chk("wr_addr_ack", 32'(r_ack), 32'd1);
        do_cmd(C_WRITE, 8'hA5);
        chk("wr_data_lat", r_lat, 32'd145);
        chk("wr_data_ack", 32'(r_ack), 32'd1);
        chk("wr_data_err", 32'(r_err), 32'd0);
        do_cmd(C_STOP, 8'h00);
        chk("wr_stop_lat",  r_lat, 32'd17);
        chk("wr_stop_busy", 32'(busy), 32'd0);
        chk("wr_stop_scl",  32'(scl_oe), 32'd0);
        chk("wr_stop_sda",  32'(sda_oe), 32'd0);
        chk("slv_wr_op",    32'(s_op), 32'd0);
        chk("slv_wr_byte",  32'(s_wr_byte), 32'hA5);
        chk("slv_wr_cnt",   s_wr_cnt, 32'd1);

        // read two bytes: ACK then NAK
        do_cmd(C_START, 8'h00);
        do_cmd(C_WRITE, 8'h45);
        chk("rd_addr_ack", 32'(r_ack), 32'd1);
        do_cmd(C_READ_ACK, 8'h00);
        chk("rd_ack_lat",   r_lat, 32'd145);
        chk("rd_ack_rdata", 32'(r_rd), 32'h3C);
        chk("rd_ack_err",   32'(r_err), 32'd0);
        do_cmd(C_READ_NAK, 8'h00);
        chk("rd_nak_rdata", 32'(r_rd), 32'hC3);
        do_cmd(C_STOP, 8'h00);
        chk("rd_stop_lat", r_lat, 32'd17);
        chk("slv_rd_op",   32'(s_op), 32'd1);
        chk("slv_mack",    32'(s_mack), 32'h1);
        chk("rdata_hold",  32'(rsp_rdata), 32'hC3);

        // address NAK: nobody at 0x50
        do_cmd(C_START, 8'h00);
        do_cmd(C_WRITE, 8'hA0);
        chk("nak_ack", 32'(r_ack), 32'd0);
        chk("nak_err", 32'(r_err), 32'd0);
        do_cmd(C_STOP, 8'h00);

        // clock stretch: 10 cycles held low during Q2 of bit 3 of the data byte
        do_cmd(C_START, 8'h00);
        do_cmd(C_WRITE, 8'h44);
        issue(C_WRITE, 8'h5A);
        fork
            wait_rsp();
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                ext_scl = 1'b1;
                repeat (10) @(negedge clk);
                ext_scl = 1'b0;
            end
        join
        chk("stretch_lat",  r_lat, 32'd155);
        chk("stretch_ack",  32'(r_ack), 32'd1);
        chk("stretch_byte", 32'(s_wr_byte), 32'h5A);
        do_cmd(C_STOP, 8'h00);

        // reserved code while the bus is held
        do_cmd(C_START, 8'h00);
        @(negedge clk);
        #1 ev0 = line_ev;
        do_cmd(3'd6, 8'h00);
        chk("rsvd_lat",  r_lat, 32'd1);
        chk("rsvd_err",  32'(r_err), 32'd1);
        chk("rsvd_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("rsvd_lines", line_ev, ev0);
        do_cmd(C_STOP, 8'h00);
        chk("rsvd_stop_lat", r_lat, 32'd17);
        chk("rsvd_stop_err", 32'(r_err), 32'd0);

        // asynchronous reset in the middle of a WRITE (bit 3, Q0, data 0x00)
        do_cmd(C_START, 8'h00);
        issue(C_WRITE, 8'h00);
        repeat (34) @(posedge clk);
        #2;
        chk("pre_rst_scl", 32'(scl_oe), 32'd1);
        chk("pre_rst_sda", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_scl", 32'(scl_oe), 32'd0);
        chk("rst_async_sda", 32'(sda_oe), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy",  32'(busy), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
        do_cmd(C_STOP, 8'h00);
        chk("post_rst_stop_lat", r_lat, 32'd1);
        chk("post_rst_stop_err", 32'(r_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Synthesizable byte-level I2C master controller. It converts single-command requests (START, STOP, WRITE byte, READ byte with ACK or NAK) into open-drain SCL/SDA waveforms. It sits directly upstream of the I2C slave bus functional model on the shared `scl`/`sda` wires, which are externally pulled up. It is the stimulus source whose transfers the slave BFM captures, acknowledges and answers.

## Interface
Parameters:
- `DIV`, default 25: system clocks per quarter SCL bit period. Legal range is 2..65535; one SCL period is 4*DIV clocks.
- `I2C_DATA_WIDTH`, default 8: bits per data byte.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller is idle and can accept a command.
- `cmd`  in  3  command code: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NAK. Codes 5–7 are reserved.
- `cmd_wdata`  in  I2C_DATA_WIDTH  byte to send on WRITE.
- `rsp_valid`  out  1  one-cycle pulse when a command completes.
- `rsp_rdata`  out  I2C_DATA_WIDTH  byte received on READ_*; holds its value until the next READ.
- `rsp_ack`  out  1  on WRITE, 1 if the slave drove ACK (sda low in the 9th bit).
- `rsp_err`  out  1  command was illegal in the current bus state.
- `busy`  out  1  the bus is held, i.e. a START has been issued and no STOP has followed.
- `scl_i`, `sda_i`  in  1  sampled line levels.
- `scl_oe`, `sda_oe`  out  1  1 = pull the line low; 0 = release it to high-Z.

## Operation
- FSM states: IDLE, START_SEQ, STOP_SEQ, BIT, RESP.
- Each sequence is built from quarters Q0..Q3. A 16-bit quarter counter counts DIV clocks per quarter.
- Command acceptance: a command is accepted when `cmd_valid && cmd_ready`. Q0 begins on the next clock.
- START (legal whether or not the bus is held; when held it is a repeated start):
  - Q0: release sda; scl unchanged.
  - Q1: release scl (stretch-wait applies).
  - Q2: assert `sda_oe` while scl is high. This is the start edge.
  - Q3: assert `scl_oe`.
  - Afterwards: `busy`=1.
- STOP:
  - Q0: assert `sda_oe`, with scl low.
  - Q1: release scl (stretch-wait applies).
  - Q2: release sda. This is the stop edge.
  - Q3: bus-free hold.
  - Afterwards: `busy`=0.
  - STOP while `busy`=0 is a no-op: no line activity; the response arrives on the next cycle with `rsp_err`=0.
- WRITE: 9 bit cells. Bits 8..1 carry `cmd_wdata`, MSB first. In bit 9, sda is released and the slave's ACK is sampled.
- READ_ACK / READ_NAK: 9 bit cells.
  - Bits 1–8: sda released, sampled MSB-first into a shift register.
  - Bit 9: `sda_oe`=1 for READ_ACK, 0 for READ_NAK.
- Bit cell:
  - Q0: `scl_oe`=1; `sda_oe` is updated on the first clock of Q0.
  - Q1: scl held low.
  - Q2: scl released.
  - Q3: scl high; `sda_i` is sampled on the first clock of Q3.
- Clock stretching: in any quarter that releases scl, the counter freezes while `scl_i`=0. Counting resumes on the first clock with `scl_i`=1.
- Illegal commands:
  - WRITE/READ with `busy`=0, or a reserved code, produces `rsp_err`=1 on the next cycle.
  - No line activity occurs; `rsp_rdata` and `rsp_ack` are unchanged.
- RESP: lasts one cycle; `rsp_valid`=1 and `cmd_ready`=1 in that same cycle, so back-to-back commands are allowed.
- Response fields: `rsp_ack` and `rsp_err` are valid only while `rsp_valid`=1. `rsp_err` is cleared on every non-error response.
- Between commands while `busy`=1: scl is held low and sda keeps its last driven value (no spurious edges).

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_ack`=0, `rsp_err`=0, `busy`=0, `scl_oe`=0, `sda_oe`=0.
- Reset mid-operation: both lines are released immediately. The FSM returns to IDLE; any partial byte is discarded.
- Latency from the accept cycle (cycle 0) to the `rsp_valid` cycle, with no stretching:
  - START/STOP: 4*DIV+1.
  - WRITE/READ: 36*DIV+1.
  - Illegal command or idle STOP: 1.
  - Stretching adds exactly the number of frozen cycles.
- While busy: `cmd_ready`=0 from cycle 1 until the RESP cycle. `cmd_wdata` is captured at accept and need not stay stable.
- All outputs are registered. There are no combinational paths from `scl_i`/`sda_i` to any output.

## Test plan
- Reset and idle checks:
  - Assert `rst` mid-WRITE with DIV=4 → `scl_oe`/`sda_oe` go to 0 in the same cycle.
  - After release, all outputs are at reset values; STOP gives `rsp_valid` after 1 cycle with `rsp_err`=0.
- Two-byte write, DIV=4, BFM at slave address 0x22:
  - Send START, WRITE 0x44, WRITE 0xA5, STOP.
  - Expect `rsp_valid` at 17/145/145/17 cycles after accept, `rsp_ack`=1 on both WRITEs.
  - Expect the BFM transfer task to return op=0 and data={0xA5}.
- Read:
  - Send START, WRITE 0x45, READ_ACK, READ_NAK, STOP, with the BFM providing {0x3C,0xC3}.
  - Expect `rsp_rdata`=0x3C then 0xC3; ACK then NAK observed on sda in the respective 9th bits.
- Address NAK: START, WRITE 0xA0 with no slave at 0x50 → `rsp_ack`=0, `rsp_err`=0.
- Clock stretch:
  - Hold scl low externally for 10 cycles during Q2 of bit 3 of a WRITE.
  - Expect `rsp_valid` delayed by exactly 10 cycles and the byte still received correctly.
- Illegal command:
  - WRITE 0x55 with `busy`=0 → `rsp_err`=1 one cycle after accept, no scl/sda edge.
  - Reserved code 6 after START → `rsp_err`=1, and `busy` stays 1.
